// File: rtl/hazard_pkg.sv
// Shared types and stage-control encodings for the pipeline hazard controller.
// fs_t: bit0 = stall (hold), bit1 = flush (insert NOP); 2'b11 is never produced.
package hazard_pkg;

  typedef logic [1:0] fs_t;

  localparam fs_t FS_NONE  = 2'b00;
  localparam fs_t FS_STALL = 2'b01;
  localparam fs_t FS_FLUSH = 2'b10;

  typedef enum logic {
    RUN,
    REDIR_WAIT
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detector.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// x0 never creates a dependency.
module load_use_detector #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      ex_mem_read_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                      id_use_rs1_i,
  input  logic                      id_use_rs2_i,
  output logic                      load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline: stage flush/stall and PC redirect.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    REG_ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR        = 32'h8000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      if_busy,
  input  logic                      mem_busy,
  input  logic                      ex_redirect,
  input  logic [ADDR_WIDTH-1:0]     ex_target,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  output logic [1:0]                pc_fs,
  output logic [1:0]                ifid_fs,
  output logic [1:0]                idex_fs,
  output logic [1:0]                exmem_fs,
  output logic [1:0]                memwb_fs,
  output logic                      pc_load,
  output logic [ADDR_WIDTH-1:0]     pc_target,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_redirects
);

  ctrl_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic                  load_use;

  load_use_detector #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
  ) u_load_use (
    .ex_mem_read_i(ex_mem_read),
    .ex_rd_i      (ex_rd),
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .load_use_o   (load_use)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      tgt_q   <= PC_ADDR;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  // The held target only drives the PC while waiting out a stale fetch.
  assign pc_target = (state_q == REDIR_WAIT) ? tgt_q : ex_target;

  always_comb begin
    pc_fs    = FS_NONE;
    ifid_fs  = FS_NONE;
    idex_fs  = FS_NONE;
    exmem_fs = FS_NONE;
    memwb_fs = FS_NONE;
    pc_load  = 1'b0;
    state_d  = state_q;
    tgt_d    = tgt_q;

    if (reset) begin
      ifid_fs  = FS_FLUSH;
      idex_fs  = FS_FLUSH;
      exmem_fs = FS_FLUSH;
      memwb_fs = FS_FLUSH;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            // A pending branch stays in EX and is re-presented after the wait.
            pc_fs    = FS_STALL;
            ifid_fs  = FS_STALL;
            idex_fs  = FS_STALL;
            exmem_fs = FS_STALL;
            memwb_fs = FS_FLUSH;
          end else if (ex_redirect && !if_busy) begin
            pc_load = 1'b1;
            ifid_fs = FS_FLUSH;
            idex_fs = FS_FLUSH;
          end else if (ex_redirect) begin
            tgt_d   = ex_target;
            state_d = REDIR_WAIT;
            pc_fs   = FS_STALL;
            ifid_fs = FS_FLUSH;
            idex_fs = FS_FLUSH;
          end else if (load_use) begin
            pc_fs   = FS_STALL;
            ifid_fs = FS_STALL;
            idex_fs = FS_FLUSH;
          end else if (if_busy) begin
            pc_fs   = FS_STALL;
            ifid_fs = FS_FLUSH;
          end
        end

        REDIR_WAIT: begin
          ifid_fs = FS_FLUSH;
          if (mem_busy) begin
            pc_fs    = FS_STALL;
            idex_fs  = FS_STALL;
            exmem_fs = FS_STALL;
            memwb_fs = FS_FLUSH;
          end else if (if_busy) begin
            pc_fs = FS_STALL;
          end else begin
            pc_load = 1'b1;
            state_d = RUN;
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redir_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (pc_fs[0]) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (pc_load)  redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_redirects    = redir_cnt_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_redirects    = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl plus multi-cycle redirect/reset sequences.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_busy, mem_busy, ex_redirect, ex_mem_read;
  logic [31:0] ex_target;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic [1:0]  pc_fs, ifid_fs, idex_fs, exmem_fs, memwb_fs;
  logic        pc_load;
  logic [31:0] pc_target, perf_stall_cycles, perf_redirects;

  int checks   = 0;
  int failures = 0;

  // Expected {pc, ifid, idex, exmem, memwb} encodings.
  localparam logic [9:0] E_IDLE   = 10'b00_00_00_00_00;
  localparam logic [9:0] E_LDUSE  = 10'b01_01_10_00_00;
  localparam logic [9:0] E_REDIR  = 10'b00_10_10_00_00;
  localparam logic [9:0] E_ENTERW = 10'b01_10_10_00_00;
  localparam logic [9:0] E_IFBUSY = 10'b01_10_00_00_00;
  localparam logic [9:0] E_MEM    = 10'b01_01_01_01_10;
  localparam logic [9:0] E_WMEM   = 10'b01_10_01_01_10;
  localparam logic [9:0] E_WREL   = 10'b00_10_00_00_00;
  localparam logic [9:0] E_RESET  = 10'b00_10_10_10_10;

  typedef struct packed {
    logic        mem_busy;
    logic        if_busy;
    logic        ex_redirect;
    logic [31:0] tgt;
    logic        ex_mem_read;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic [9:0]  efs;
    logic        epl;
  } vec_t;

  vec_t vecs [13];

  pipeline_hazard_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .if_busy          (if_busy),
    .mem_busy         (mem_busy),
    .ex_redirect      (ex_redirect),
    .ex_target        (ex_target),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_use_rs1       (id_use_rs1),
    .id_use_rs2       (id_use_rs2),
    .pc_fs            (pc_fs),
    .ifid_fs          (ifid_fs),
    .idex_fs          (idex_fs),
    .exmem_fs         (exmem_fs),
    .memwb_fs         (memwb_fs),
    .pc_load          (pc_load),
    .pc_target        (pc_target),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_redirects   (perf_redirects)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic mb, input logic ib, input logic rd_en, input logic [31:0] t,
                              input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                              input logic u1, input logic u2, input logic [9:0] efs, input logic epl);
    vec_t v;
    v.mem_busy = mb;  v.if_busy = ib;  v.ex_redirect = rd_en;  v.tgt = t;
    v.ex_mem_read = mr;  v.rd = rd;  v.rs1 = r1;  v.rs2 = r2;
    v.use1 = u1;  v.use2 = u2;  v.efs = efs;  v.epl = epl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [9:0] efs, input logic epl, input logic [31:0] etgt);
    logic [9:0] fs_all;
    fs_all = {pc_fs, ifid_fs, idex_fs, exmem_fs, memwb_fs};
    $display("[%0t] %s fs=%b pc_load=%b pc_target=%08h", $time, tag, fs_all, pc_load, pc_target);
    chk({tag, ".fs"}, {22'd0, fs_all}, {22'd0, efs});
    chk({tag, ".pc_load"}, {31'd0, pc_load}, {31'd0, epl});
    chk({tag, ".pc_target"}, pc_target, etgt);
  endtask

  task automatic set_idle();
    if_busy = 1'b0;  mem_busy = 1'b0;  ex_redirect = 1'b0;  ex_target = 32'h0000_1000;
    ex_mem_read = 1'b0;  ex_rd = 5'd0;  id_rs1 = 5'd0;  id_rs2 = 5'd0;
    id_use_rs1 = 1'b0;  id_use_rs2 = 1'b0;
  endtask

  // Ends the current cycle and returns just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 32'h0000_1000, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_IDLE,  0);
    vecs[1]  = mk(0, 0, 0, 32'h0000_1004, 1, 5'd5, 5'd5, 5'd0, 1, 0, E_LDUSE, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0000_1008, 1, 5'd0, 5'd0, 5'd0, 1, 0, E_IDLE,  0);
    vecs[3]  = mk(0, 0, 0, 32'h0000_100c, 1, 5'd7, 5'd3, 5'd7, 0, 1, E_LDUSE, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0000_1010, 1, 5'd7, 5'd3, 5'd7, 1, 0, E_IDLE,  0);
    vecs[5]  = mk(0, 0, 0, 32'h0000_1014, 0, 5'd9, 5'd9, 5'd9, 1, 1, E_IDLE,  0);
    vecs[6]  = mk(0, 0, 1, 32'h8000_0040, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_REDIR, 1);
    vecs[7]  = mk(0, 1, 0, 32'h0000_1018, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_IFBUSY, 0);
    vecs[8]  = mk(1, 0, 0, 32'h0000_101c, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_MEM,   0);
    vecs[9]  = mk(1, 0, 1, 32'h8000_0080, 0, 5'd0, 5'd0, 5'd0, 0, 0, E_MEM,   0);
    vecs[10] = mk(0, 1, 0, 32'h0000_1020, 1, 5'd4, 5'd4, 5'd0, 1, 0, E_LDUSE, 0);
    vecs[11] = mk(0, 0, 1, 32'h8000_00c0, 1, 5'd4, 5'd4, 5'd0, 1, 0, E_REDIR, 1);
    vecs[12] = mk(1, 1, 0, 32'h0000_1024, 1, 5'd4, 5'd4, 5'd0, 1, 0, E_MEM,   0);

    set_idle();
    reset = 1'b1;
    @(negedge clk);
    check_outs("reset", E_RESET, 1'b0, 32'h0000_1000);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("reset.tgt_q", dut.tgt_q, 32'h8000_0000);
    check_outs("post_reset", E_IDLE, 1'b0, 32'h0000_1000);
    next_cycle();

    for (int i = 0; i < 13; i++) begin
      mem_busy = vecs[i].mem_busy;  if_busy = vecs[i].if_busy;  ex_redirect = vecs[i].ex_redirect;
      ex_target = vecs[i].tgt;  ex_mem_read = vecs[i].ex_mem_read;  ex_rd = vecs[i].rd;
      id_rs1 = vecs[i].rs1;  id_rs2 = vecs[i].rs2;  id_use_rs1 = vecs[i].use1;  id_use_rs2 = vecs[i].use2;
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].efs, vecs[i].epl, vecs[i].tgt);
      next_cycle();
    end
    set_idle();

    // Busy redirect: fetch busy for three cycles, a memory wait, then release.
    ex_redirect = 1'b1;  ex_target = 32'h8000_0100;  if_busy = 1'b1;
    @(negedge clk);
    check_outs("busy_redir.enter", E_ENTERW, 1'b0, 32'h8000_0100);
    next_cycle();
    ex_redirect = 1'b0;  ex_target = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_outs($sformatf("busy_redir.wait%0d", c), E_IFBUSY, 1'b0, 32'h8000_0100);
      next_cycle();
    end
    if_busy = 1'b0;  mem_busy = 1'b1;
    @(negedge clk);
    check_outs("busy_redir.memwait", E_WMEM, 1'b0, 32'h8000_0100);
    next_cycle();
    mem_busy = 1'b0;
    @(negedge clk);
    check_outs("busy_redir.release", E_WREL, 1'b1, 32'h8000_0100);
    next_cycle();
    @(negedge clk);
    check_outs("busy_redir.run", E_IDLE, 1'b0, 32'h1234_5678);
    next_cycle();

    // Memory wait holds a branch for two cycles; it is taken once the wait clears.
    mem_busy = 1'b1;  ex_redirect = 1'b1;  ex_target = 32'h8000_0200;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_outs($sformatf("mem_vs_br.wait%0d", c), E_MEM, 1'b0, 32'h8000_0200);
      next_cycle();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    check_outs("mem_vs_br.take", E_REDIR, 1'b1, 32'h8000_0200);
    next_cycle();
    set_idle();

    // Reset while waiting on a fetch drops the held target.
    ex_redirect = 1'b1;  ex_target = 32'h8000_0300;  if_busy = 1'b1;
    @(negedge clk);
    check_outs("rst_wait.enter", E_ENTERW, 1'b0, 32'h8000_0300);
    next_cycle();
    ex_redirect = 1'b0;  ex_target = 32'h0000_2000;  reset = 1'b1;
    @(negedge clk);
    check_outs("rst_wait.reset", E_RESET, 1'b0, 32'h8000_0300);
    next_cycle();
    reset = 1'b0;  if_busy = 1'b0;  ex_target = 32'hdead_beef;
    @(negedge clk);
    chk("rst_wait.tgt_q", dut.tgt_q, 32'h8000_0000);
    check_outs("rst_wait.run", E_IDLE, 1'b0, 32'hdead_beef);
    next_cycle();

    // Perf counters: four PC stalls and two redirects after a fresh reset.
    set_idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    if_busy = 1'b1;
    repeat (4) next_cycle();
    if_busy = 1'b0;  ex_redirect = 1'b1;  ex_target = 32'h8000_0400;
    repeat (2) next_cycle();
    set_idle();
    @(negedge clk);
    $display("[%0t] perf stall=%0d redirects=%0d", $time, perf_stall_cycles, perf_redirects);
`ifdef HAZARD_PERF_EN
    chk("perf.stall_cycles", perf_stall_cycles, 32'd4);
    chk("perf.redirects", perf_redirects, 32'd2);
`else
    chk("perf.stall_cycles", perf_stall_cycles, 32'd0);
    chk("perf.redirects", perf_redirects, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
